fp_div_seq: RTL and testbench
=============================

Name: fp_div_seq

Overview:
- Iterative IEEE-754 single-precision divider; computes result = a / b. It is the inverse-operation companion to the team's combinational single-precision multiplier.
- Uses a restoring radix-2 mantissa divider with a start/done handshake and fixed latency. It sits beside the multiplier in the floating-point arithmetic group.
- Denormal inputs and outputs are flushed to zero. Rounding is round-to-nearest-even by default.

Parameters:
- ROUND_MODE, 0, 0 = round-to-nearest-even; 1 = truncate toward zero.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division; accepted only when busy=0.
- a  input  32  dividend (IEEE-754 single); sampled in the accept cycle.
- b  input  32  divisor (IEEE-754 single); sampled in the accept cycle.
- busy  output  1  high from the cycle after accept through the ROUND state.
- done  output  1  one-cycle pulse; result and flags are valid from this cycle.
- result  output  32  quotient; holds its value until the next accept or reset.
- div_by_zero  output  1  finite nonzero / zero; valid with done and held with result.
- invalid  output  1  NaN operand, 0/0 or inf/inf; valid with done and held with result.

Behaviour:
- Reset (rst=1 at a clock edge): state returns to IDLE; busy=0, done=0, result=32'h0, div_by_zero=0, invalid=0. This applies in any state, including mid-division; a pending operation is discarded.
- States and transitions:
  - IDLE: go to UNPACK on start=1.
  - UNPACK: 1 cycle.
  - DIVIDE: exactly 26 cycles.
  - ROUND: 1 cycle.
  - DONE: 1 cycle, done=1, then return to IDLE.
- Latency and handshake:
  - start is accepted in cycle 0, busy=1 in cycles 1..28, done=1 in cycle 29.
  - Back-to-back operation: start may be asserted in the DONE cycle and is accepted there, since busy=0.
  - start while busy=1 is ignored, with no effect on the in-flight operation.
- Operands: a and b are latched at accept; changes on a and b during busy have no effect.
- Operand classification (UNPACK):
  - exp=0 is treated as zero, sign kept.
  - exp=255 with frac=0 is inf; exp=255 with frac!=0 is NaN.
- Special cases:
  - All special cases still run the full fixed latency (done at cycle 29); only the final mux differs.
  - Any NaN operand, 0/0, or inf/inf: result=32'h7FC00000, invalid=1.
  - Finite nonzero / 0: result = signed inf (sign = sa^sb), div_by_zero=1.
  - inf / finite: signed inf.
  - 0 / finite nonzero, and finite / inf: signed zero.
- Normal datapath:
  - Mantissas: ma = {1,fa}, mb = {1,fb}, 24 bits each.
  - Restoring division produces q[25:0] = floor(ma/mb * 2^25), one bit per DIVIDE cycle, MSB first; the remainder is kept 25 bits wide.
  - Exponent: e = ea - eb + 127, computed as a signed 10-bit value.
- Normalisation (ROUND state):
  - If q[25]=1: mantissa = q[24:2], guard = q[1], sticky = q[0] | (rem!=0).
  - Otherwise: mantissa = q[23:1], guard = q[0], sticky = (rem!=0), and e = e-1.
- Rounding:
  - RNE: increment the mantissa when guard & (sticky | lsb).
  - Truncate: never increment.
  - If the increment carries out of the mantissa, the mantissa becomes 0 and e = e+1.
- Range limits:
  - e >= 255 after rounding: result = signed inf (overflow); flags stay 0.
  - e <= 0: result = signed zero (flush-to-zero underflow).
- Sign: the result sign is always sa^sb, including for zero and inf results; NaN output uses sign 0.

Test Plan:
- Basic quotient: rst 2 cycles, then start with a=32'h40000000, b=32'h3F800000 -> done exactly 29 cycles after accept, result=32'h40000000, flags 0, busy high for cycles 1..28.
- Rounding: a=32'h3F800000, b=32'h40400000 (1/3) -> result=32'h3EAAAAAB with ROUND_MODE=0, and 32'h3EAAAAAA with ROUND_MODE=1. Also a=32'hC0C00000, b=32'h40000000 -> 32'hC0400000.
- Special values:
  - 32'h3F800000/32'h00000000 -> 32'h7F800000, div_by_zero=1.
  - 32'h00000000/32'h00000000 -> 32'h7FC00000, invalid=1.
  - 32'h7F800000/32'h7F800000 -> 32'h7FC00000, invalid=1.
  - 32'h80000000/32'h40000000 -> 32'h80000000.
- Range limits: 32'h7F000000/32'h3E800000 -> 32'h7F800000 (overflow); 32'h00800000/32'h40000000 -> 32'h00000000 (flush); 32'h00400000/32'h3F800000 -> 32'h00000000 (denormal input).
- Handshake: pulse start with new operands at cycle 10 of an operation -> ignored, first result unchanged. Then a back-to-back start in the DONE cycle -> accepted, second done 29 cycles later.
- Mid-operation reset: assert rst at cycle 15 of an operation -> next cycle busy=0, done=0, result=0; no done pulse follows; a fresh start then completes normally.

Source files
------------

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider: restoring radix-2 mantissa
// divide, fixed 29-cycle latency from accept to done, denormals flushed to zero.
//
// state  | meaning
// IDLE   | waiting for start
// UNPACK | classify operands, load divider and exponent
// DIVIDE | 26 restoring steps, one quotient bit per cycle
// ROUND  | normalise, round, range-limit, latch result
// DONE   | done pulse; a new start is accepted here
module fp_div_seq #(
  parameter int ROUND_MODE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        div_by_zero,
  output logic        invalid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_DIVIDE,
    S_ROUND,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic              accept;
  logic [31:0]       a_r, b_r;
  logic [4:0]        cnt;
  logic [24:0]       rem;
  logic [23:0]       mb;
  logic [25:0]       q;
  logic signed [9:0] exp_r;
  logic              sign_r;
  logic              spec_r, spec_inv_r, spec_dbz_r;
  logic [31:0]       spec_res_r;

  // operand fields
  logic       sa, sb;
  logic [7:0] ea, eb;
  logic [22:0] fa, fb;
  logic       za, zb, ia, ib, na, nb, sgn;

  // special-case selection
  logic        spec_nxt, spec_inv_nxt, spec_dbz_nxt;
  logic [31:0] spec_res_nxt;

  // divide step
  logic        ge;
  logic [24:0] diff, rem_nxt;

  // normalise / round
  logic [22:0]       mant, mant_fin;
  logic              guard, sticky, inc;
  logic [23:0]       mant_inc;
  logic signed [9:0] e_norm, e_fin;
  logic [31:0]       norm_res;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_UNPACK;
      S_UNPACK: state_nxt = S_DIVIDE;
      S_DIVIDE: if (cnt == 5'd0) state_nxt = S_ROUND;
      S_ROUND:  state_nxt = S_DONE;
      S_DONE:   state_nxt = start ? S_UNPACK : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_UNPACK, S_DIVIDE, S_ROUND: busy = 1'b1;
      S_DONE:                      done = 1'b1;
      default: ;
    endcase
  end

  assign accept = start & ~busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= 32'h0;
      b_r <= 32'h0;
    end else if (accept) begin
      a_r <= a;
      b_r <= b;
    end
  end

  assign sa  = a_r[31];
  assign sb  = b_r[31];
  assign ea  = a_r[30:23];
  assign eb  = b_r[30:23];
  assign fa  = a_r[22:0];
  assign fb  = b_r[22:0];
  assign za  = (ea == 8'd0);
  assign zb  = (eb == 8'd0);
  assign ia  = (ea == 8'hFF) && (fa == 23'd0);
  assign ib  = (eb == 8'hFF) && (fb == 23'd0);
  assign na  = (ea == 8'hFF) && (fa != 23'd0);
  assign nb  = (eb == 8'hFF) && (fb != 23'd0);
  assign sgn = sa ^ sb;

  always_comb begin
    spec_nxt     = 1'b1;
    spec_inv_nxt = 1'b0;
    spec_dbz_nxt = 1'b0;
    spec_res_nxt = 32'h7FC0_0000;
    if (na || nb || (za && zb) || (ia && ib)) begin
      spec_inv_nxt = 1'b1;
    end else if (zb) begin
      // inf/0 is just a signed infinity; only a finite dividend raises the flag
      spec_res_nxt = {sgn, 8'hFF, 23'd0};
      spec_dbz_nxt = ~ia;
    end else if (ia) begin
      spec_res_nxt = {sgn, 8'hFF, 23'd0};
    end else if (za || ib) begin
      spec_res_nxt = {sgn, 31'd0};
    end else begin
      spec_nxt = 1'b0;
    end
  end

  // Remainder stays below 2*mb, so 25 bits never overflow.
  assign ge      = (rem >= {1'b0, mb});
  assign diff    = rem - {1'b0, mb};
  assign rem_nxt = ge ? {diff[23:0], 1'b0} : {rem[23:0], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      rem        <= 25'd0;
      mb         <= 24'd0;
      q          <= 26'd0;
      cnt        <= 5'd0;
      exp_r      <= 10'sd0;
      sign_r     <= 1'b0;
      spec_r     <= 1'b0;
      spec_inv_r <= 1'b0;
      spec_dbz_r <= 1'b0;
      spec_res_r <= 32'h0;
    end else begin
      case (state)
        S_UNPACK: begin
          rem        <= {2'b01, fa};
          mb         <= {1'b1, fb};
          q          <= 26'd0;
          cnt        <= 5'd25;
          exp_r      <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
          sign_r     <= sgn;
          spec_r     <= spec_nxt;
          spec_inv_r <= spec_inv_nxt;
          spec_dbz_r <= spec_dbz_nxt;
          spec_res_r <= spec_res_nxt;
        end
        S_DIVIDE: begin
          q   <= {q[24:0], ge};
          rem <= rem_nxt;
          cnt <= cnt - 5'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    if (q[25]) begin
      mant   = q[24:2];
      guard  = q[1];
      sticky = q[0] | (|rem);
      e_norm = exp_r;
    end else begin
      mant   = q[23:1];
      guard  = q[0];
      sticky = |rem;
      e_norm = exp_r - 10'sd1;
    end
    inc      = (ROUND_MODE == 0) && guard && (sticky || mant[0]);
    mant_inc = {1'b0, mant} + {23'd0, inc};
    if (mant_inc[23]) begin
      mant_fin = 23'd0;
      e_fin    = e_norm + 10'sd1;
    end else begin
      mant_fin = mant_inc[22:0];
      e_fin    = e_norm;
    end
    if (e_fin >= 10'sd255)   norm_res = {sign_r, 8'hFF, 23'd0};
    else if (e_fin <= 10'sd0) norm_res = {sign_r, 31'd0};
    else                      norm_res = {sign_r, e_fin[7:0], mant_fin};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result      <= 32'h0;
      invalid     <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (state == S_ROUND) begin
      result      <= spec_r ? spec_res_r : norm_res;
      invalid     <= spec_r & spec_inv_r;
      div_by_zero <= spec_r & spec_dbz_r;
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Bench for fp_div_seq: two instances (RNE and truncate) against an
// arithmetic reference model, plus directed literal cases.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] a_in, b_in;
  logic        busy0, done0, dbz0, inv0;
  logic        busy1, done1, dbz1, inv1;
  logic [31:0] res0, res1;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  int          ph;
  logic [31:0] p_a, p_b;
  logic [33:0] m0, m1;

  always #5 clk = ~clk;

  fp_div_seq #(.ROUND_MODE(0)) u_rne (
    .clk(clk), .rst(rst), .start(start), .a(a_in), .b(b_in),
    .busy(busy0), .done(done0), .result(res0),
    .div_by_zero(dbz0), .invalid(inv0)
  );

  fp_div_seq #(.ROUND_MODE(1)) u_trn (
    .clk(clk), .rst(rst), .start(start), .a(a_in), .b(b_in),
    .busy(busy1), .done(done1), .result(res1),
    .div_by_zero(dbz1), .invalid(inv1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: {invalid, div_by_zero, result}
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input int mode);
    logic s, za, zb, ia, ib, na, nb, g, st;
    int ex, ey, e;
    longint unsigned ma, mb, num, q, r, mant;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    za = (ex == 0);
    zb = (ey == 0);
    ia = (ex == 255) && (x[22:0] == 0);
    ib = (ey == 255) && (y[22:0] == 0);
    na = (ex == 255) && (x[22:0] != 0);
    nb = (ey == 255) && (y[22:0] != 0);
    if (na || nb || (za && zb) || (ia && ib)) return {2'b10, 32'h7FC00000};
    if (zb) return {1'b0, !ia, s, 8'hFF, 23'd0};
    if (ia) return {2'b00, s, 8'hFF, 23'd0};
    if (za || ib) return {2'b00, s, 31'd0};
    ma  = 64'h800000 + 64'(x[22:0]);
    mb  = 64'h800000 + 64'(y[22:0]);
    num = ma * 64'd33554432;
    q   = num / mb;
    r   = num % mb;
    e   = ex - ey + 127;
    if (q >= 64'd33554432) begin
      mant = (q / 4) % 64'd8388608;
      g    = ((q / 2) % 2) == 1;
      st   = ((q % 2) == 1) || (r != 0);
    end else begin
      mant = (q / 2) % 64'd8388608;
      g    = (q % 2) == 1;
      st   = (r != 0);
      e    = e - 1;
    end
    if (mode == 0 && g && (st || (mant % 2) == 1)) mant = mant + 1;
    if (mant == 64'd8388608) begin
      mant = 0;
      e    = e + 1;
    end
    if (e >= 255) return {2'b00, s, 8'hFF, 23'd0};
    if (e <= 0)   return {2'b00, s, 31'd0};
    return {2'b00, s, 8'(e), 23'(mant)};
  endfunction

  // Cycle-level model of the handshake: ph = cycles since accept (0 = idle)
  always @(posedge clk) begin
    if (rst) begin
      ph <= 0;
      m0 <= 34'd0;
      m1 <= 34'd0;
    end else begin
      if ((ph == 0 || ph == 29) && start) begin
        ph  <= 1;
        p_a <= a_in;
        p_b <= b_in;
      end else if (ph >= 1 && ph <= 28) begin
        ph <= ph + 1;
      end else begin
        ph <= 0;
      end
      if (ph == 28) begin
        m0 <= model(p_a, p_b, 0);
        m1 <= model(p_a, p_b, 1);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic eb, ed;
      eb = (ph >= 1 && ph <= 28);
      ed = (ph == 29);
      chk("busy_rne", 32'(busy0), 32'(eb));
      chk("done_rne", 32'(done0), 32'(ed));
      chk("busy_trn", 32'(busy1), 32'(eb));
      chk("done_trn", 32'(done1), 32'(ed));
      if (!eb) begin
        chk("result_rne", res0, m0[31:0]);
        chk("flags_rne", {30'd0, inv0, dbz0}, {30'd0, m0[33:32]});
        chk("result_trn", res1, m1[31:0]);
        chk("flags_trn", {30'd0, inv1, dbz1}, {30'd0, m1[33:32]});
      end
    end
  end

  task automatic issue(input logic [31:0] x, input logic [31:0] y);
    a_in  = x;
    b_in  = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (!done0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!done0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout actual=no_done required=done_within_40");
    end
  endtask

  task automatic directed(input string nm, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] e0, input logic [31:0] e1,
                          input logic ei, input logic ed);
    int c;
    issue(x, y);
    wait_done(1, c);
    chk({nm, "_latency"}, 32'(c), 32'd29);
    chk({nm, "_rne"}, res0, e0);
    chk({nm, "_trn"}, res1, e1);
    chk({nm, "_flags"}, {30'd0, inv0, dbz0}, {30'd0, ei, ed});
  endtask

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] f;
    int k;
    k = $urandom_range(0, 15);
    f = 23'($urandom);
    case (k)
      0:       e = 8'd0;
      1:       begin e = 8'hFF; f = 23'd0; end
      2:       e = 8'hFF;
      3:       e = 8'($urandom_range(1, 20));
      4:       e = 8'($urandom_range(235, 254));
      5:       begin e = 8'($urandom_range(100, 154)); f = 23'd0; end
      default: e = 8'($urandom_range(1, 254));
    endcase
    return {1'($urandom), e, f};
  endfunction

  initial begin
    int c, seen;
    rst   = 1'b1;
    start = 1'b0;
    a_in  = 32'h0;
    b_in  = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_result", res0, 32'h0);
    rst    = 1'b0;
    chk_en = 1'b1;

    directed("basic",   32'h40000000, 32'h3F800000, 32'h40000000, 32'h40000000, 0, 0);
    directed("third",   32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 32'h3EAAAAAA, 0, 0);
    directed("neg",     32'hC0C00000, 32'h40000000, 32'hC0400000, 32'hC0400000, 0, 0);
    directed("divzero", 32'h3F800000, 32'h00000000, 32'h7F800000, 32'h7F800000, 0, 1);
    directed("zz",      32'h00000000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 1, 0);
    directed("ii",      32'h7F800000, 32'h7F800000, 32'h7FC00000, 32'h7FC00000, 1, 0);
    directed("negzero", 32'h80000000, 32'h40000000, 32'h80000000, 32'h80000000, 0, 0);
    directed("ovf",     32'h7F000000, 32'h3E800000, 32'h7F800000, 32'h7F800000, 0, 0);
    directed("uflow",   32'h00800000, 32'h40000000, 32'h00000000, 32'h00000000, 0, 0);
    directed("denorm",  32'h00400000, 32'h3F800000, 32'h00000000, 32'h00000000, 0, 0);
    repeat (3) @(negedge clk);

    // start during busy is ignored; start in the DONE cycle is accepted
    issue(32'h40000000, 32'h3F800000);
    repeat (9) @(negedge clk);
    issue(32'h3F800000, 32'h40400000);
    wait_done(11, c);
    chk("ignore_latency", 32'(c), 32'd29);
    chk("ignore_result", res0, 32'h40000000);
    issue(32'h3F800000, 32'h40400000);
    wait_done(1, c);
    chk("b2b_latency", 32'(c), 32'd29);
    chk("b2b_result", res0, 32'h3EAAAAAB);
    repeat (2) @(negedge clk);

    // reset mid-division discards the operation
    issue(32'h40000000, 32'h3F800000);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_done", 32'(done0), 32'd0);
    chk("midrst_result", res0, 32'h0);
    seen = 0;
    repeat (35) begin
      @(negedge clk);
      if (done0) seen++;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);
    directed("after_rst", 32'hC0C00000, 32'h40000000, 32'hC0400000, 32'hC0400000, 0, 0);

    // random traffic: start, operands and rare resets every cycle
    repeat (6000) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      a_in  = rand_fp();
      b_in  = rand_fp();
      rst   = ($urandom_range(0, 999) == 0);
    end
    start = 1'b0;
    rst   = 1'b0;
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
